// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and the
// instruction memory or cache.
`timescale 1ns/1ps
interface if_stage_if;
   logic [15:0] imemAddr;
   logic        imemRe;
   logic        imemRdy;
   logic [15:0] imemData;

   modport master (output imemAddr, output imemRe, input imemRdy, input imemData);
   modport slave  (input imemAddr, input imemRe, output imemRdy, output imemData);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a ready handshake, and
// drives the IF/ID register with stall buffering, redirect flush and halt.
`timescale 1ns/1ps
module if_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0000,
   parameter logic [3:0]  HLT_OP    = 4'hF
) (
   input  logic        i_clk,
   input  logic        i_nRst,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [15:0] i_target,
   if_stage_if.master  imem,
   output logic [15:0] o_instr,
   output logic [15:0] o_pc,
   output logic        o_valid,
   output logic        o_fetchHlt
);

   typedef enum logic [1:0] {FETCH, KILL, HALTED} state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] tgt_q, tgt_d;
   logic        pend_q, pend_d;
   logic        hb_vld_q, hb_vld_d;
   logic [15:0] hb_data_q, hb_data_d;
   logic [15:0] hb_pc_q, hb_pc_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] ifpc_q, ifpc_d;
   logic        valid_q, valid_d;

   logic        re_raw;
   logic        re;
   logic        acc;
   logic [15:0] pc_inc;
   logic        ld;
   logic [15:0] ld_instr;
   logic [15:0] ld_pc;

   // A request already in flight keeps re high even if stall rises.
   always_comb begin
      case (state_q)
         FETCH:   re_raw = pend_q || (!i_stall && !hb_vld_q);
         KILL:    re_raw = 1'b1;
         default: re_raw = 1'b0;
      endcase
   end

   assign re            = re_raw && i_nRst;
   assign acc           = re && imem.imemRdy;
   assign pc_inc        = pc_q + 16'd1;
   assign imem.imemRe   = re;
   assign imem.imemAddr = pc_q;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      tgt_d     = tgt_q;
      pend_d    = pend_q;
      hb_vld_d  = hb_vld_q;
      hb_data_d = hb_data_q;
      hb_pc_d   = hb_pc_q;
      instr_d   = instr_q;
      ifpc_d    = ifpc_q;
      valid_d   = valid_q;
      ld        = 1'b0;
      ld_instr  = hb_data_q;
      ld_pc     = hb_pc_q;

      if (i_redirect) begin
         instr_d  = NOP_INSTR;
         ifpc_d   = 16'h0000;
         valid_d  = 1'b0;
         hb_vld_d = 1'b0;
         if (re && !imem.imemRdy) begin
            // pc keeps the old address so the bus stays stable until the stale word returns
            state_d = KILL;
            tgt_d   = i_target;
            pend_d  = 1'b1;
         end else begin
            state_d = FETCH;
            pc_d    = i_target;
            pend_d  = 1'b0;
         end
      end else begin
         case (state_q)
            FETCH: begin
               pend_d = re && !imem.imemRdy;
               if (acc) begin
                  pc_d = pc_inc;
                  if (i_stall) begin
                     hb_vld_d  = 1'b1;
                     hb_data_d = imem.imemData;
                     hb_pc_d   = pc_inc;
                  end else begin
                     ld       = 1'b1;
                     ld_instr = imem.imemData;
                     ld_pc    = pc_inc;
                  end
               end else if (!i_stall && hb_vld_q) begin
                  ld       = 1'b1;
                  hb_vld_d = 1'b0;
               end
            end
            KILL: begin
               if (imem.imemRdy) begin
                  state_d = FETCH;
                  pc_d    = tgt_q;
                  pend_d  = 1'b0;
               end
            end
            default: ;
         endcase

         if (ld) begin
            instr_d = ld_instr;
            ifpc_d  = ld_pc;
            valid_d = 1'b1;
            if (ld_instr[15:12] == HLT_OP) begin
               state_d = HALTED;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_nRst) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         tgt_q    <= RESET_PC;
         pend_q   <= 1'b0;
         hb_vld_q <= 1'b0;
         instr_q  <= NOP_INSTR;
         ifpc_q   <= 16'h0000;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         tgt_q    <= tgt_d;
         pend_q   <= pend_d;
         hb_vld_q <= hb_vld_d;
         instr_q  <= instr_d;
         ifpc_q   <= ifpc_d;
         valid_q  <= valid_d;
      end
   end

   always_ff @(posedge i_clk) begin
      hb_data_q <= hb_data_d;
      hb_pc_q   <= hb_pc_d;
   end

   assign o_instr    = instr_q;
   assign o_pc       = ifpc_q;
   assign o_valid    = valid_q;
   assign o_fetchHlt = (state_q == HALTED);

endmodule
